// File: rtl/fetch_gshare.sv
// Instruction-fetch stage with gshare branch prediction: owns the fetch PC,
// the 2-bit counter pattern history table, the global history and the IF/ID register.
module fetch_gshare #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          GHR_BITS  = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                upd_en,
  input  logic [GHR_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  output logic [31:0]         imem_addr0,
  input  logic [31:0]         imem_rdata0,
  output logic [31:0]         imem_addr1,
  input  logic [31:0]         imem_rdata1,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic [31:0]         instr1,
  output logic                prediction,
  output logic [GHR_BITS-1:0] pc_xor_global_history,
  output logic                valid
);

  localparam int        PHT_SIZE  = 1 << GHR_BITS;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0]         fetch_pc_reg;
  logic [31:0]         fetch_pc_next;
  logic [GHR_BITS-1:0] ghr_reg;
  logic [1:0]          pht_reg [PHT_SIZE];
  logic [GHR_BITS-1:0] pred_idx;
  logic                is_branch;
  logic                pred_taken;
  logic [31:0]         b_imm;
  logic [1:0]          upd_ctr;
  logic [1:0]          upd_ctr_next;

  assign imem_addr0 = fetch_pc_reg;
  assign imem_addr1 = fetch_pc_reg + 32'd4;

  // Prediction is purely combinational on the current fetch PC and committed history.
  assign pred_idx   = fetch_pc_reg[GHR_BITS+1:2] ^ ghr_reg;
  assign is_branch  = (imem_rdata0[6:0] == OP_BRANCH);
  assign pred_taken = is_branch & pht_reg[pred_idx][1];
  assign b_imm      = {{20{imem_rdata0[31]}}, imem_rdata0[7], imem_rdata0[30:25],
                       imem_rdata0[11:8], 1'b0};
  assign fetch_pc_next = pred_taken ? (fetch_pc_reg + b_imm) : (fetch_pc_reg + 32'd4);

  assign upd_ctr = pht_reg[upd_idx];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'd1;
    end
  end

  // Training is driven only by resolved branches, so it ignores stall and redirect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_reg[i] <= 2'b01;
      ghr_reg <= '0;
    end else if (upd_en) begin
      pht_reg[upd_idx] <= upd_ctr_next;
      ghr_reg          <= {ghr_reg[GHR_BITS-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_reg          <= RESET_PC;
      pc                    <= '0;
      instr                 <= NOP_INSTR;
      instr1                <= '0;
      prediction            <= 1'b0;
      pc_xor_global_history <= '0;
      valid                 <= 1'b0;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_pc;
      instr        <= NOP_INSTR;
      prediction   <= 1'b0;
      valid        <= 1'b0;
    end else if (!stall) begin
      fetch_pc_reg          <= fetch_pc_next;
      pc                    <= fetch_pc_reg;
      instr                 <= imem_rdata0;
      instr1                <= imem_rdata1;
      prediction            <= pred_taken;
      pc_xor_global_history <= pred_idx;
      valid                 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_gshare.sv
// Randomized bench for fetch_gshare against a table-and-arithmetic reference
// of the fetch PC, counters, history and the IF/ID contents.
module tb_fetch_gshare;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BR_P20   = 32'h0200_0063;  // beq x0,x0,+0x20

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, redirect, upd_en, upd_taken;
  logic [31:0] redirect_pc;
  logic [7:0]  upd_idx;
  logic [31:0] imem_addr0, imem_rdata0, imem_addr1, imem_rdata1;
  logic [31:0] pc, instr, instr1;
  logic        prediction, valid;
  logic [7:0]  pc_xor_global_history;

  logic [31:0] mem [1024];
  assign imem_rdata0 = mem[imem_addr0[11:2]];
  assign imem_rdata1 = mem[imem_addr1[11:2]];

  always #5 clk = ~clk;

  fetch_gshare dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .imem_addr0(imem_addr0), .imem_rdata0(imem_rdata0),
    .imem_addr1(imem_addr1), .imem_rdata1(imem_rdata1),
    .pc(pc), .instr(instr), .instr1(instr1), .prediction(prediction),
    .pc_xor_global_history(pc_xor_global_history), .valid(valid)
  );

  // Reference state
  logic [31:0] m_pc;
  int          m_ghr;
  int          m_pht [256];
  logic [31:0] e_pc, e_instr, e_instr1;
  logic        e_pred, e_valid;
  logic [7:0]  e_idx;

  int checks = 0;
  int errors = 0;

  logic [169:0] dut_obs, exp_obs, obs_mask;
  assign dut_obs = {pc, instr, instr1, prediction, pc_xor_global_history, valid, imem_addr0, imem_addr1};
  assign exp_obs = {e_pc, e_instr, e_instr1, e_pred, e_idx, e_valid, m_pc, m_pc + 32'd4};
  // A bubble only defines instr, prediction and valid.
  assign obs_mask = e_valid ? {170{1'b1}}
                            : {32'h0, {32{1'b1}}, 32'h0, 1'b1, 8'h0, 1'b1, {64{1'b1}}};

  task automatic model_reset();
    m_pc = RESET_PC;
    m_ghr = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    e_pc = 0; e_instr = NOP; e_instr1 = 0; e_pred = 0; e_idx = 0; e_valid = 0;
  endtask

  task automatic tick(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit ue, input logic [7:0] ui, input bit ut);
    logic [31:0] w0, w1, a1;
    int idx, off;
    bit br, pr;
    @(negedge clk);
    stall = st; redirect = rd; redirect_pc = rpc;
    upd_en = ue; upd_idx = ui; upd_taken = ut;
    a1  = m_pc + 32'd4;
    w0  = mem[m_pc[11:2]];
    w1  = mem[a1[11:2]];
    idx = ((m_pc / 4) % 256) ^ m_ghr;
    br  = (w0 % 128) == 99;
    pr  = br && (m_pht[idx] >= 2);
    off = (w0[31] ? -4096 : 0) + w0[7] * 2048 + w0[30:25] * 32 + w0[11:8] * 2;
    if (rd) begin
      m_pc = rpc; e_instr = NOP; e_valid = 0; e_pred = 0;
    end else if (!st) begin
      e_pc = m_pc; e_instr = w0; e_instr1 = w1; e_pred = pr; e_idx = 8'(idx); e_valid = 1;
      m_pc = pr ? m_pc + 32'(off) : m_pc + 32'd4;
    end
    if (ue) begin
      if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
      else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      m_ghr = (m_ghr * 2 + int'(ut)) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    checks++;
    if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
      errors++; $display("FAIL reset_pre got %h exp %h", dut_obs, exp_obs);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({pc, instr, instr1, prediction, pc_xor_global_history, valid, imem_addr0} !==
        {32'h0, NOP, 32'h0, 1'b0, 8'h0, 1'b0, RESET_PC}) begin
      errors++; $display("FAIL reset_async got %h %h %h %b %h %b %h exp reset values",
                         pc, instr, instr1, prediction, pc_xor_global_history, valid, imem_addr0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== RESET_PC || valid !== 1'b1) begin
      errors++; $display("FAIL reset_first_fetch got pc=%h valid=%b exp pc=%h valid=1", pc, valid, RESET_PC);
    end
    checks++;
    if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
      errors++; $display("FAIL reset_post got %h exp %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_sequential();
    tick(0, 1, 32'h0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      checks++;
      if (pc !== 32'(4 * i) || prediction !== 1'b0 || instr1 !== mem[i + 1]) begin
        errors++; $display("FAIL seq_step%0d got pc=%h pred=%b instr1=%h exp pc=%h pred=0 instr1=%h",
                           i, pc, prediction, instr1, 32'(4 * i), mem[i + 1]);
      end
      checks++;
      if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
        errors++; $display("FAIL seq_obs%0d got %h exp %h", i, dut_obs, exp_obs);
      end
    end
  endtask

  task automatic test_training();
    tick(0, 0, 0, 1, 8'h10, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 8'(8'h80 + i), 0);  // flush history back to 0
    mem[16] = BR_P20;
    tick(0, 1, 32'h40, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h40 || prediction !== 1'b1 || pc_xor_global_history !== 8'h10 || imem_addr0 !== 32'h60) begin
      errors++; $display("FAIL train_pred got pc=%h pred=%b idx=%h next=%h exp pc=40 pred=1 idx=10 next=60",
                         pc, prediction, pc_xor_global_history, imem_addr0);
    end
    checks++;
    if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
      errors++; $display("FAIL train_obs got %h exp %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_saturation();
    logic [7:0]  x;
    logic [31:0] a;
    x = 8'($urandom_range(160, 191));
    repeat (4) tick(0, 0, 0, 1, x, 0);
    tick(0, 0, 0, 1, x, 1);
    a = 32'(((int'(x) ^ m_ghr) % 256) * 4);
    mem[a[11:2]] = BR_P20;
    tick(0, 1, a, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (prediction !== 1'b0 || pc_xor_global_history !== x) begin
      errors++; $display("FAIL sat_low got pred=%b idx=%h exp pred=0 idx=%h", prediction, pc_xor_global_history, x);
    end
    repeat (5) tick(0, 0, 0, 1, x, 1);
    tick(0, 0, 0, 1, x, 0);
    a = 32'(((int'(x) ^ m_ghr) % 256) * 4);
    mem[a[11:2]] = BR_P20;
    tick(0, 1, a, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (prediction !== 1'b1 || pc_xor_global_history !== x) begin
      errors++; $display("FAIL sat_high got pred=%b idx=%h exp pred=1 idx=%h", prediction, pc_xor_global_history, x);
    end
    checks++;
    if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
      errors++; $display("FAIL sat_obs got %h exp %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    tick(0, 1, 32'h200, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    held = m_pc;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 1, 8'($urandom), 1'($urandom));
      checks++;
      if (imem_addr0 !== held || (dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
        errors++; $display("FAIL stall_hold%0d got %h exp %h", i, dut_obs, exp_obs);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      checks++;
      if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
        errors++; $display("FAIL stall_release%0d got %h exp %h", i, dut_obs, exp_obs);
      end
    end
  endtask

  task automatic test_redirect_stall();
    tick(1, 1, 32'h100, 0, 0, 0);
    checks++;
    if (valid !== 1'b0 || instr !== NOP || prediction !== 1'b0) begin
      errors++; $display("FAIL redir_bubble got valid=%b instr=%h pred=%b exp valid=0 instr=%h pred=0",
                         valid, instr, prediction, NOP);
    end
    tick(0, 0, 0, 0, 0, 0);
    checks++;
    if (pc !== 32'h100 || valid !== 1'b1 || (dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
      errors++; $display("FAIL redir_fetch got %h exp %h", dut_obs, exp_obs);
    end
  endtask

  task automatic test_random();
    logic [31:0] w, rpc;
    bit st, rd, ue;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 3) w[6:0] = 7'h63;
      mem[i] = w;
    end
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      ue  = ($urandom_range(0, 9) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      tick(st, rd, rpc, ue, 8'($urandom), 1'($urandom));
      checks++;
      if ((dut_obs & obs_mask) !== (exp_obs & obs_mask)) begin
        errors++; $display("FAIL rand%0d got %h exp %h", i, dut_obs, exp_obs);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; stall = 0; redirect = 0; redirect_pc = 0; upd_en = 0; upd_idx = 0; upd_taken = 0;
    for (int i = 0; i < 1024; i++)
      mem[i] = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
    model_reset();
    #23;
    @(posedge clk); #1;
    rstn = 1'b1;
    test_reset();
    test_sequential();
    test_training();
    test_saturation();
    test_stall();
    test_redirect_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
